// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM. Sequences fetch/decode/exec/mem/writeback with
// variable-latency memory handshakes, counts retirements and halts on EBREAK/illegal/timeout.
module multicycle_control_unit #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      im_data,
  input  logic             im_ready,
  input  logic             dm_ready,
  input  logic             ALUzero,
  input  logic             ALUneg,
  output logic             im_req,
  output logic             dm_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             ALUsrc,
  output logic [1:0]       PCsrc,
  output logic [1:0]       MemWrite,
  output logic [2:0]       ALUctl,
  output logic [2:0]       MemtoReg,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_SYS = 7'b1110011;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_AND = 3'b001, ALU_OR = 3'b010, ALU_SL = 3'b011,
                         ALU_SRA = 3'b100, ALU_SRL = 3'b101, ALU_SUB = 3'b110, ALU_XOR = 3'b111;

  localparam int WC_W = $clog2(WAIT_LIMIT + 1);

  state_t            state_q, state_d;
  logic [31:0]       ir_q;
  logic [WC_W-1:0]   wait_q;
  logic [CNT_W-1:0]  instret_q;
  logic              halted_q, illegal_q, timeout_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_load, is_store, is_br, is_lui, is_auipc, is_jal, is_jalr;
  logic       is_ebreak, legal, taken, ir_unused;
  logic [2:0] alu_dec, m2r_dec;
  logic [1:0] mw_dec;
  logic       alusrc_dec;

  logic       waiting, ready_now, limit_hit;
  logic       ir_we, retire, set_halt, set_illegal, set_timeout;
  logic       im_req_c, dm_req_c, pc_we_c, reg_we_c, alusrc_c;
  logic [1:0] pcsrc_c, mw_c;
  logic [2:0] aluctl_c, m2r_c;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign ir_unused = ^{ir_q[31], ir_q[29:21], ir_q[19:15], ir_q[11:7]};

  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_br     = (opcode == OP_BR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_ebreak = (opcode == OP_SYS) && ir_q[20];

  assign legal = is_r || is_i || is_lui || is_auipc || is_jal || is_jalr
              || ((is_load || is_store) && (funct3 inside {3'b000, 3'b001, 3'b010}))
              || (is_br && (funct3 inside {3'b000, 3'b001, 3'b100, 3'b101}));

  // Only R-type and branches compare two registers; everything else takes the immediate.
  assign alusrc_dec = !(is_r || is_br);

  always_comb begin
    alu_dec = ALU_ADD;
    if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_dec = (is_r && ir_q[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_dec = ALU_SL;
        3'b010,
        3'b011:  alu_dec = ALU_SUB;
        3'b100:  alu_dec = ALU_XOR;
        3'b101:  alu_dec = ir_q[30] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_dec = ALU_OR;
        default: alu_dec = ALU_AND;
      endcase
    end else if (is_br) begin
      alu_dec = ALU_SUB;
    end
  end

  always_comb begin
    m2r_dec = 3'b000;
    if (is_load) begin
      case (funct3)
        3'b000:  m2r_dec = 3'b100;
        3'b001:  m2r_dec = 3'b101;
        default: m2r_dec = 3'b110;
      endcase
    end else if (is_lui) begin
      m2r_dec = 3'b010;
    end else if (is_auipc) begin
      m2r_dec = 3'b011;
    end else if ((is_r || is_i) && (funct3 inside {3'b010, 3'b011})) begin
      m2r_dec = 3'b111;
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  mw_dec = 2'b01;
      3'b001:  mw_dec = 2'b10;
      default: mw_dec = 2'b11;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = ALUzero;
      3'b001:  taken = !ALUzero;
      3'b100:  taken = ALUneg;
      3'b101:  taken = !ALUneg;
      default: taken = 1'b0;
    endcase
  end

  // Ready arriving in the limit cycle takes priority over the timeout.
  assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign ready_now = ((state_q == S_FETCH) && im_ready) || ((state_q == S_MEM) && dm_ready);
  assign limit_hit = waiting && !ready_now && (wait_q == WC_W'(WAIT_LIMIT - 1));

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ir_we       = 1'b0;
    retire      = 1'b0;
    set_halt    = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    im_req_c    = 1'b0;
    dm_req_c    = 1'b0;
    pc_we_c     = 1'b0;
    reg_we_c    = 1'b0;
    alusrc_c    = 1'b0;
    pcsrc_c     = 2'b00;
    mw_c        = 2'b00;
    aluctl_c    = ALU_ADD;
    m2r_c       = 3'b000;
    case (state_q)
      S_FETCH: begin
        im_req_c = 1'b1;
        if (im_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (limit_hit) begin
          state_d     = S_HALT;
          set_halt    = 1'b1;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_ebreak) begin
          state_d  = S_HALT;
          set_halt = 1'b1;
        end else if (!legal) begin
          state_d     = S_HALT;
          set_halt    = 1'b1;
          set_illegal = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alusrc_c = alusrc_dec;
        aluctl_c = alu_dec;
        if (is_br) begin
          pc_we_c = 1'b1;
          pcsrc_c = taken ? 2'b01 : 2'b00;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_jal || is_jalr) begin
          pc_we_c  = 1'b1;
          pcsrc_c  = is_jal ? 2'b01 : 2'b10;
          reg_we_c = 1'b1;
          m2r_c    = 3'b001;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dm_req_c = 1'b1;
        alusrc_c = 1'b1;
        aluctl_c = ALU_ADD;
        if (is_store) mw_c = mw_dec;
        if (dm_ready) begin
          if (is_store) begin
            pc_we_c = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (limit_hit) begin
          state_d     = S_HALT;
          set_halt    = 1'b1;
          set_timeout = 1'b1;
        end
      end
      S_WB: begin
        alusrc_c = alusrc_dec;
        aluctl_c = alu_dec;
        reg_we_c = 1'b1;
        m2r_c    = m2r_dec;
        pc_we_c  = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= 32'h0000_0013;
      wait_q    <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_we) ir_q <= im_data;
      if (state_d != state_q)         wait_q <= '0;
      else if (waiting && !ready_now) wait_q <= wait_q + 1'b1;
      if (retire) instret_q <= instret_q + 1'b1;
      halted_q  <= halted_q  | set_halt;
      illegal_q <= illegal_q | set_illegal;
      timeout_q <= timeout_q | set_timeout;
    end
  end

  // Reset gates every output combinationally so a store in flight drops MemWrite immediately.
  assign im_req   = !rst && im_req_c;
  assign dm_req   = !rst && dm_req_c;
  assign IRWrite  = !rst && ir_we;
  assign PCWrite  = !rst && pc_we_c;
  assign RegWrite = !rst && reg_we_c;
  assign ALUsrc   = !rst && alusrc_c;
  assign PCsrc    = rst ? 2'b00 : pcsrc_c;
  assign MemWrite = rst ? 2'b00 : mw_c;
  assign ALUctl   = rst ? 3'b000 : aluctl_c;
  assign MemtoReg = rst ? 3'b000 : m2r_c;
  assign state    = rst ? 3'd0 : state_q;
  assign halted   = !rst && halted_q;
  assign illegal  = !rst && illegal_q;
  assign timeout  = !rst && timeout_q;
  assign instret  = rst ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: per-instruction expected cycle
// sequences derived from the instruction class and the handshake delays chosen.
module tb_multicycle_control_unit;
  localparam int WL = 4;
  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] im_data;
  logic        im_ready, dm_ready, ALUzero, ALUneg;
  logic        im_req, dm_req, IRWrite, PCWrite, RegWrite, ALUsrc;
  logic [1:0]  PCsrc, MemWrite;
  logic [2:0]  ALUctl, MemtoReg, state;
  logic        halted, illegal, timeout;
  logic [CW-1:0] instret;
  logic [21:0] obs;

  multicycle_control_unit #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .im_data(im_data), .im_ready(im_ready), .dm_ready(dm_ready),
    .ALUzero(ALUzero), .ALUneg(ALUneg), .im_req(im_req), .dm_req(dm_req),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUsrc(ALUsrc),
    .PCsrc(PCsrc), .MemWrite(MemWrite), .ALUctl(ALUctl), .MemtoReg(MemtoReg),
    .state(state), .halted(halted), .illegal(illegal), .timeout(timeout), .instret(instret)
  );

  always #5 clk = ~clk;

  assign obs = {state, im_req, dm_req, IRWrite, PCWrite, RegWrite, ALUsrc,
                PCsrc, MemWrite, ALUctl, MemtoReg, halted, illegal, timeout};

  typedef enum {K_R, K_I, K_LOAD, K_STORE, K_BR, K_LUI, K_AUIPC, K_JAL, K_JALR, K_EBREAK, K_ILL} kind_t;

  int errors = 0;
  int checks = 0;
  bit m_halt, m_ill, m_to;
  int m_ret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic kind_t kind_of(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    case (w[6:0])
      7'h33: return K_R;
      7'h13: return K_I;
      7'h03: return (f3 <= 3'd2) ? K_LOAD : K_ILL;
      7'h23: return (f3 <= 3'd2) ? K_STORE : K_ILL;
      7'h63: return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5) ? K_BR : K_ILL;
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      7'h6F: return K_JAL;
      7'h67: return K_JALR;
      7'h73: return w[20] ? K_EBREAK : K_ILL;
      default: return K_ILL;
    endcase
  endfunction

  // add,and,or,sl,sra,srl,sub,xor = 0..7
  function automatic logic [2:0] alu_of(input logic [31:0] w, input kind_t k);
    logic [2:0] f3;
    f3 = w[14:12];
    if (k == K_BR) return 3'd6;
    if (k != K_R && k != K_I) return 3'd0;
    case (f3)
      3'd0: return (k == K_R && w[30]) ? 3'd6 : 3'd0;
      3'd1: return 3'd3;
      3'd2, 3'd3: return 3'd6;
      3'd4: return 3'd7;
      3'd5: return w[30] ? 3'd4 : 3'd5;
      3'd6: return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] m2r_of(input logic [31:0] w, input kind_t k);
    logic [2:0] f3;
    f3 = w[14:12];
    if (k == K_LOAD) return 3'd4 + f3;
    if (k == K_LUI) return 3'd2;
    if (k == K_AUIPC) return 3'd3;
    if ((k == K_R || k == K_I) && (f3 == 3'd2 || f3 == 3'd3)) return 3'd7;
    return 3'd0;
  endfunction

  function automatic logic [21:0] mk(input logic [2:0] st, input logic imr, input logic dmr,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic asrc, input logic [1:0] pcs, input logic [1:0] mw,
                                     input logic [2:0] ac, input logic [2:0] m2r);
    return {st, imr, dmr, irw, pcw, rw, asrc, pcs, mw, ac, m2r, m_halt, m_ill, m_to};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_noise();
    logic [31:0] r;
    r = $urandom;
    im_ready = r[0];
    dm_ready = r[1];
    ALUzero  = r[2];
    ALUneg   = r[3];
    im_data  = $urandom;
  endtask

  task automatic retired();
    m_ret++;
    check("instret", 32'(instret), 32'(m_ret % (1 << CW)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_noise();
    #1;
    check("rst_outputs", 32'(obs), 32'd0);
    check("rst_instret", 32'(instret), 32'd0);
    tick();
    rst = 1'b0;
    m_halt = 1'b0; m_ill = 1'b0; m_to = 1'b0; m_ret = 0;
  endtask

  task automatic halt_and_reset();
    for (int h = 0; h < 2; h++) begin
      drive_noise();
      #1 check("halt", 32'(obs), 32'(mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0)));
      tick();
    end
    do_reset();
  endtask

  // fd/md: cycles of delay before ready (WL means never); rst_at: MEM cycle to reset in; zf: forced ALUzero.
  task automatic run_instr(input logic [31:0] w, input int fd, input int md, input int rst_at, input int zf);
    kind_t      k;
    logic       asrc, tk, st;
    logic [2:0] ac, f3;
    logic [1:0] mw;
    k    = kind_of(w);
    f3   = w[14:12];
    asrc = !(k == K_R || k == K_BR);
    ac   = alu_of(w, k);
    st   = (k == K_STORE);
    mw   = 2'(f3) + 2'd1;

    for (int i = 0; i < WL; i++) begin
      drive_noise();
      im_ready = (i == fd);
      if (i == fd) im_data = w;
      #1 check("fetch", 32'(obs), 32'(mk(3'd0, 1'b1, 1'b0, (i == fd), 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0)));
      tick();
      if (i == fd) break;
      if (i == WL - 1) begin
        m_halt = 1'b1; m_to = 1'b1;
        halt_and_reset();
        return;
      end
    end

    drive_noise();
    #1 check("decode", 32'(obs), 32'(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0)));
    tick();
    if (k == K_EBREAK || k == K_ILL) begin
      m_halt = 1'b1; m_ill = (k == K_ILL);
      halt_and_reset();
      return;
    end

    drive_noise();
    if (zf >= 0) ALUzero = zf[0];
    case (f3)
      3'd0: tk = ALUzero;
      3'd1: tk = !ALUzero;
      3'd4: tk = ALUneg;
      default: tk = !ALUneg;
    endcase
    case (k)
      K_BR:    #1 check("exec_br", 32'(obs), 32'(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, asrc, tk ? 2'd1 : 2'd0, 2'd0, ac, 3'd0)));
      K_JAL:   #1 check("exec_jal", 32'(obs), 32'(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, asrc, 2'd1, 2'd0, ac, 3'd1)));
      K_JALR:  #1 check("exec_jalr", 32'(obs), 32'(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, asrc, 2'd2, 2'd0, ac, 3'd1)));
      default: #1 check("exec", 32'(obs), 32'(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, asrc, 2'd0, 2'd0, ac, 3'd0)));
    endcase
    tick();
    if (k == K_BR || k == K_JAL || k == K_JALR) begin
      retired();
      return;
    end

    if (k == K_LOAD || st) begin
      for (int j = 0; j < WL; j++) begin
        drive_noise();
        dm_ready = (j == md);
        #1 check("mem", 32'(obs), 32'(mk(3'd3, 1'b0, 1'b1, 1'b0, st && (j == md), 1'b0, 1'b1, 2'd0,
                                       st ? mw : 2'd0, 3'd0, 3'd0)));
        if (j == rst_at) begin
          rst = 1'b1;
          #1 check("mem_rst_memwrite", 32'(MemWrite), 32'd0);
          tick();
          rst = 1'b0;
          m_halt = 1'b0; m_ill = 1'b0; m_to = 1'b0; m_ret = 0;
          check("mem_rst_state", 32'(state), 32'd0);
          check("mem_rst_instret", 32'(instret), 32'd0);
          return;
        end
        tick();
        if (j == md) break;
        if (j == WL - 1) begin
          m_halt = 1'b1; m_to = 1'b1;
          halt_and_reset();
          return;
        end
      end
      if (st) begin
        retired();
        return;
      end
    end

    drive_noise();
    #1 check("wb", 32'(obs), 32'(mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, asrc, 2'd0, 2'd0, ac, m2r_of(w, k))));
    tick();
    retired();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: begin w[6:0] = 7'h33; w[31] = 1'b0; w[29:25] = 5'd0; end
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;
      7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h67;
      9: w[6:0] = 7'h73;
      default: ;
    endcase
    return w;
  endfunction

  function automatic int rand_delay();
    return ($urandom_range(0, 9) == 0) ? WL : int'($urandom_range(0, WL - 1));
  endfunction

  initial begin
    rst = 1'b1;
    drive_noise();
    tick();
    do_reset();

    run_instr(32'h002081B3, 0, 0, -1, -1);   // add
    run_instr(32'h0000A183, 0, 3, -1, -1);   // lw, ready in the limit cycle
    run_instr(32'h00208463, 0, 0, -1, 1);    // beq taken
    run_instr(32'h00208463, 1, 0, -1, 0);    // beq not taken
    run_instr(32'h00209023, 0, 3, 1, -1);    // sh interrupted by reset in MEM
    run_instr(32'h002081B3, WL, 0, -1, -1);  // fetch timeout
    run_instr(32'h00100073, 0, 0, -1, -1);   // ebreak
    run_instr(32'hFFFFFFFF, 0, 0, -1, -1);   // illegal
    for (int n = 0; n < 5; n++) run_instr(32'h002081B3, 0, 0, -1, -1);
    run_instr(32'h0000A183, 2, WL, -1, -1);  // load data timeout

    for (int n = 0; n < 120; n++) run_instr(rand_instr(), rand_delay(), rand_delay(), -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequenced RV32I control unit for the multicycle datapath: replaces the single-cycle combinational decoder with an FSM that fetches, decodes, executes, accesses memory and writes back over several cycles. It handshakes with instruction and data memories of variable latency, keeps the established ALUctl/MemtoReg/PCsrc/MemWrite encodings, counts retired instructions and halts on EBREAK, illegal opcode or memory timeout.

## Interface
- WAIT_LIMIT, 16: max cycles a memory request may stay unanswered before timeout halt (>=1).
- CNT_W, 32: width of retired-instruction counter.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- im_data  in  32  instruction word, valid when im_ready=1.
- im_ready  in  1  instruction memory response strobe.
- dm_ready  in  1  data memory completion strobe.
- ALUzero, ALUneg  in  1 each  ALU flags, valid in EXEC.
- im_req / dm_req  out  1 each  memory request, held until ready.
- IRWrite, PCWrite, RegWrite, ALUsrc  out  1 each  datapath strobes.
- PCsrc  out  2  00 PC+4, 01 PC+imm, 10 reg+imm.
- MemWrite  out  2  00 none, 01 byte, 10 half, 11 word.
- ALUctl  out  3  000 add,001 and,010 or,011 sl,100 sra,101 srl,110 sub,111 xor.
- MemtoReg  out  3  000 alu,001 link,010 lui,011 auipc,100 lb,101 lh,110 lw,111 slt.
- state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 5.
- halted, illegal, timeout  out  1 each  sticky status.
- instret  out  CNT_W  retired-instruction count.

## Operation
- Internal 32-bit IR latched from im_data in FETCH when im_ready=1 (IRWrite=1 that cycle). All decode uses IR, never im_data outside FETCH.
- FETCH: im_req=1; stay until im_ready; then DECODE.
- DECODE: opcode 1110011 with IR[20]=1 (EBREAK) -> HALT, halted=1. Opcode not in {R, I-ALU, load, store, branch, lui, auipc, jal, jalr}, or load/store funct3 not in {000,001,010}, or branch funct3 not in {000,001,100,101} -> HALT, halted=1, illegal=1. Else EXEC.
- EXEC: ALUsrc/ALUctl driven from IR with same decode as single-cycle unit (branch sub; load/store/auipc/jal/jalr add; slt/slti sub).
  - branch: PCWrite=1, PCsrc=01 if taken (beq zero, bne !zero, blt neg, bge !neg) else 00; retire; -> FETCH.
  - jal/jalr: PCWrite=1, PCsrc=01/10, RegWrite=1, MemtoReg=001; retire; -> FETCH.
  - load/store -> MEM; all others -> WB.
- MEM: dm_req=1, ALUctl=add, ALUsrc=1; stores drive MemWrite per funct3 (only in MEM). On dm_ready: store -> PCWrite=1, PCsrc=00, retire, FETCH; load -> WB.
- WB: RegWrite=1, MemtoReg per class (load width, lui, auipc, slt, alu), PCWrite=1, PCsrc=00, retire; -> FETCH.
- HALT: all strobes 0; exit only via rst.
- Strobes not listed for a state are 0.
- Retire: instret += 1, wrapping modulo 2^CNT_W.
- Timeout: wait counter clears on state entry, increments each cycle in FETCH/MEM without ready; if reaching WAIT_LIMIT with ready still 0 -> HALT, halted=1, timeout=1. Ready arriving in the limit cycle wins.

## Timing
- Reset: next edge state=FETCH, IR=0x00000013, instret=0, halted/illegal/timeout=0, wait counter 0. While rst=1 all outputs forced 0 combinationally (including im_req, dm_req, MemWrite).
- rst mid-MEM store: MemWrite drops in same cycle; no retire.
- Outputs are combinational from state, IR, flags; no registered strobe delay.
- Zero-wait latency (ready same cycle as req): branch/jal/jalr 3 cycles, ALU/lui/auipc/store 4, load 5. Each wait cycle adds one.
- Ready seen outside FETCH/MEM is ignored.

## Test plan
- Reset then add x3,x1,x2 (0x002081B3), im_ready always 1 -> states 0,1,2,4; WB: RegWrite=1, MemtoReg=000, ALUctl=000; instret=1.
- lw (0x0000A183) with dm_ready delayed 3 cycles -> dm_req high 4 cycles, MemtoReg=110 in WB, 8 cycles total.
- beq (0x00208463) with ALUzero=1 -> PCsrc=01, PCWrite=1 in EXEC; with ALUzero=0 -> PCsrc=00.
- sh (0x00209023), rst asserted during MEM -> MemWrite 10 then 00 same cycle, state=FETCH, instret unchanged.
- im_ready held 0, WAIT_LIMIT=4 -> HALT after 4 cycles, timeout=1, halted=1; ebreak 0x00100073 -> halted=1, illegal=0; 0xFFFFFFFF -> illegal=1.
- CNT_W=2, five adds -> instret 1,2,3,0,1.
